// File: rtl/branch_hazard_unit_if.sv
// Bundle between the ID-stage pipeline and the branch hazard unit: decoded branch
// type, compare flags, register fields, and the resulting PC/pipeline control.
interface branch_hazard_unit_if;
  logic       gt_bra;
  logic       le_bra;
  logic       eq_bra;
  logic       cmp_gt;
  logic       cmp_eq;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic [3:0] ex_rd;
  logic [3:0] mem_rd;
  logic       ex_regWrite;
  logic       ex_memRead;
  logic       mem_memRead;
  logic       pcsrc1;
  logic       pcsrc2;
  logic       pc_write;
  logic       if_id_write;
  logic       id_bubble;

  modport master (
    output gt_bra, le_bra, eq_bra, cmp_gt, cmp_eq,
    output id_rs, id_rt, ex_rd, mem_rd,
    output ex_regWrite, ex_memRead, mem_memRead,
    input  pcsrc1, pcsrc2, pc_write, if_id_write, id_bubble
  );

  modport slave (
    input  gt_bra, le_bra, eq_bra, cmp_gt, cmp_eq,
    input  id_rs, id_rt, ex_rd, mem_rd,
    input  ex_regWrite, ex_memRead, mem_memRead,
    output pcsrc1, pcsrc2, pc_write, if_id_write, id_bubble
  );
endinterface

// File: rtl/branch_hazard_unit.sv
// Branch resolution in ID with stall on EX/MEM data hazards, plus taken-branch and
// stall-cycle statistics counters.
//
// state   | meaning
// IDLE    | normal flow; hazards checked, unstalled branches resolved (pcsrc1)
// STALL   | pipeline frozen, bubble into ID/EX; scnt counts remaining stall cycles
// RESOLVE | stalled branch resolved from latched type and fresh compare (pcsrc2)
module branch_hazard_unit (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_clr,
  branch_hazard_unit_if.slave   hz,
  output logic [15:0]           br_taken_cnt,
  output logic [15:0]           stall_cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] scnt, scnt_nxt;
  logic       br_l, br_l_nxt;
  logic [2:0] typ_l, typ_l_nxt;   // {gt, le, eq}

  logic       is_br;
  logic       match_ex;
  logic       match_mem;
  logic       taken_cur;
  logic       taken_lat;
  logic       pcsrc1, pcsrc2, pc_write, if_id_write, id_bubble;

  function automatic logic taken_f(input logic gt, input logic le, input logic eq,
                                   input logic cgt, input logic ceq);
    logic t;
    if (eq)      t = ceq;
    else if (gt) t = cgt;
    else if (le) t = ~cgt;
    else         t = 1'b0;
    return t;
  endfunction

  always_comb begin
    is_br     = hz.gt_bra | hz.le_bra | hz.eq_bra;
    match_ex  = (hz.ex_rd != 4'd0) & ((hz.ex_rd == hz.id_rs) | (hz.ex_rd == hz.id_rt));
    match_mem = (hz.mem_rd != 4'd0) & ((hz.mem_rd == hz.id_rs) | (hz.mem_rd == hz.id_rt));
    taken_cur = taken_f(hz.gt_bra, hz.le_bra, hz.eq_bra, hz.cmp_gt, hz.cmp_eq);
    taken_lat = taken_f(typ_l[2], typ_l[1], typ_l[0], hz.cmp_gt, hz.cmp_eq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= 2'd0;
      br_l  <= 1'b0;
      typ_l <= 3'b000;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      br_l  <= br_l_nxt;
      typ_l <= typ_l_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    br_l_nxt    = br_l;
    typ_l_nxt   = typ_l;
    pcsrc1      = 1'b0;
    pcsrc2      = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_bubble   = 1'b0;

    case (state)
      IDLE: begin
        if (is_br & hz.ex_regWrite & match_ex) begin
          state_nxt = STALL;
          scnt_nxt  = hz.ex_memRead ? 2'd2 : 2'd1;
          br_l_nxt  = 1'b1;
          typ_l_nxt = {hz.gt_bra, hz.le_bra, hz.eq_bra};
        end else if (is_br & hz.mem_memRead & match_mem) begin
          state_nxt = STALL;
          scnt_nxt  = 2'd1;
          br_l_nxt  = 1'b1;
          typ_l_nxt = {hz.gt_bra, hz.le_bra, hz.eq_bra};
        end else if (~is_br & hz.ex_memRead & match_ex) begin
          state_nxt = STALL;
          scnt_nxt  = 2'd1;
          br_l_nxt  = 1'b0;
          typ_l_nxt = 3'b000;
        end else begin
          pcsrc1 = is_br & taken_cur;
        end
      end
      STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_bubble   = 1'b1;
        // scnt == 0 cannot occur legally; exit rather than wrap to 3
        if (scnt <= 2'd1) begin
          scnt_nxt  = 2'd0;
          state_nxt = br_l ? RESOLVE : IDLE;
        end else begin
          scnt_nxt = scnt - 2'd1;
        end
      end
      RESOLVE: begin
        pcsrc2    = taken_lat;
        state_nxt = IDLE;
        br_l_nxt  = 1'b0;
        typ_l_nxt = 3'b000;
      end
      default: begin
        state_nxt = IDLE;
        scnt_nxt  = 2'd0;
        br_l_nxt  = 1'b0;
        typ_l_nxt = 3'b000;
      end
    endcase

    // Outputs must look idle while reset is held, whatever the inputs do
    if (!rst_n) begin
      pcsrc1      = 1'b0;
      pcsrc2      = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      id_bubble   = 1'b0;
    end
  end

  assign hz.pcsrc1      = pcsrc1;
  assign hz.pcsrc2      = pcsrc2;
  assign hz.pc_write    = pc_write;
  assign hz.if_id_write = if_id_write;
  assign hz.id_bubble   = id_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt  <= 16'd0;
      stall_cyc_cnt <= 16'd0;
    end else if (cnt_clr) begin
      br_taken_cnt  <= 16'd0;
      stall_cyc_cnt <= 16'd0;
    end else begin
      if ((pcsrc1 | pcsrc2) && (br_taken_cnt != 16'hFFFF))
        br_taken_cnt <= br_taken_cnt + 16'd1;
      if ((state == STALL) && (stall_cyc_cnt != 16'hFFFF))
        stall_cyc_cnt <= stall_cyc_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed scoreboard bench for branch_hazard_unit: the driver pushes hand-computed
// expectations per cycle, a monitor on the falling edge pops and compares.
module tb_branch_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] br_taken_cnt;
  logic [15:0] stall_cyc_cnt;

  branch_hazard_unit_if bus ();

  branch_hazard_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cnt_clr       (cnt_clr),
    .hz            (bus),
    .br_taken_cnt  (br_taken_cnt),
    .stall_cyc_cnt (stall_cyc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rst;    // value driven onto rst_n
    logic       clr;
    logic       gt, le, eq, cgt, ceq;
    logic [3:0] rs, rt, exrd, memrd;
    logic       exrw, exmr, memmr;
  } stim_t;

  typedef struct packed {
    logic        p1, p2, stall;
    logic [15:0] bc, sc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] ebc = 16'd0;
  logic [15:0] esc = 16'd0;

  function automatic stim_t sv(logic rst, logic clr, logic gt, logic le, logic eq,
                               logic cgt, logic ceq, logic [3:0] rs, logic [3:0] rt,
                               logic [3:0] exrd, logic [3:0] memrd,
                               logic exrw, logic exmr, logic memmr);
    stim_t s;
    s.rst = rst; s.clr = clr; s.gt = gt; s.le = le; s.eq = eq;
    s.cgt = cgt; s.ceq = ceq; s.rs = rs; s.rt = rt; s.exrd = exrd; s.memrd = memrd;
    s.exrw = exrw; s.exmr = exmr; s.memmr = memmr;
    return s;
  endfunction

  task automatic step(input stim_t s, input logic p1, input logic p2, input logic st);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = s.rst;
    cnt_clr         = s.clr;
    bus.gt_bra      = s.gt;
    bus.le_bra      = s.le;
    bus.eq_bra      = s.eq;
    bus.cmp_gt      = s.cgt;
    bus.cmp_eq      = s.ceq;
    bus.id_rs       = s.rs;
    bus.id_rt       = s.rt;
    bus.ex_rd       = s.exrd;
    bus.mem_rd      = s.memrd;
    bus.ex_regWrite = s.exrw;
    bus.ex_memRead  = s.exmr;
    bus.mem_memRead = s.memmr;
    if (!s.rst) begin
      ebc = 16'd0;
      esc = 16'd0;
    end
    e.p1 = p1; e.p2 = p2; e.stall = st; e.bc = ebc; e.sc = esc;
    sb_q.push_back(e);
    // counter values the next edge should produce
    if (s.rst) begin
      if (s.clr) begin
        ebc = 16'd0;
        esc = 16'd0;
      end else begin
        if ((p1 | p2) && ebc != 16'hFFFF) ebc = ebc + 16'd1;
        if (st && esc != 16'hFFFF)        esc = esc + 16'd1;
      end
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (bus.pcsrc1 !== e.p1) begin
          miscompares++;
          $display("FAIL pcsrc1 vec %0d: got %b want %b", vectors, bus.pcsrc1, e.p1);
        end
        if (bus.pcsrc2 !== e.p2) begin
          miscompares++;
          $display("FAIL pcsrc2 vec %0d: got %b want %b", vectors, bus.pcsrc2, e.p2);
        end
        if (bus.pc_write !== ~e.stall || bus.if_id_write !== ~e.stall) begin
          miscompares++;
          $display("FAIL write_en vec %0d: got pc_write=%b if_id_write=%b want %b",
                   vectors, bus.pc_write, bus.if_id_write, ~e.stall);
        end
        if (bus.id_bubble !== e.stall) begin
          miscompares++;
          $display("FAIL id_bubble vec %0d: got %b want %b", vectors, bus.id_bubble, e.stall);
        end
        if (bus.pcsrc1 === 1'b1 && bus.pcsrc2 === 1'b1) begin
          miscompares++;
          $display("FAIL pcsrc_excl vec %0d: got both 1 want at most one", vectors);
        end
        if (br_taken_cnt !== e.bc) begin
          miscompares++;
          $display("FAIL br_taken_cnt vec %0d: got %h want %h", vectors, br_taken_cnt, e.bc);
        end
        if (stall_cyc_cnt !== e.sc) begin
          miscompares++;
          $display("FAIL stall_cyc_cnt vec %0d: got %h want %h", vectors, stall_cyc_cnt, e.sc);
        end
      end
    end
  end

  initial begin
    stim_t z, t, lu, bl, rz;
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    bus.gt_bra = 0; bus.le_bra = 0; bus.eq_bra = 0; bus.cmp_gt = 0; bus.cmp_eq = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.ex_rd = 0; bus.mem_rd = 0;
    bus.ex_regWrite = 0; bus.ex_memRead = 0; bus.mem_memRead = 0;

    z  = sv(1,0, 0,0,0, 0,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0);
    t  = sv(1,0, 0,0,1, 0,1, 4'd0,4'd0, 4'd0,4'd0, 0,0,0);
    lu = sv(1,0, 0,0,0, 0,0, 4'd3,4'd0, 4'd3,4'd0, 1,1,0);
    bl = sv(1,0, 1,0,0, 1,0, 4'd0,4'd5, 4'd5,4'd0, 1,1,0);

    // reset holds outputs idle even with a taken branch on the inputs
    step(sv(0,0, 0,0,1, 0,1, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,0,0);
    step(sv(0,0, 0,0,1, 0,1, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,0,0);

    // taken eq branch, no hazard
    step(t, 1,0,0);
    step(z, 0,0,0);

    // load-use on non-branch: one stall cycle
    step(lu, 0,0,0);
    step(lu, 0,0,1);
    step(z,  0,0,0);

    // branch on load: two stalls, then resolve with latched gt type
    step(bl, 0,0,0);
    step(bl, 0,0,1);
    step(bl, 0,0,1);
    step(sv(1,0, 0,0,0, 1,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,1,0);
    step(z,  0,0,0);

    // branch on ALU result: one stall, le not taken in resolve
    step(sv(1,0, 0,1,0, 0,0, 4'd2,4'd0, 4'd2,4'd0, 1,0,0), 0,0,0);
    step(sv(1,0, 0,1,0, 0,0, 4'd2,4'd0, 4'd2,4'd0, 1,0,0), 0,0,1);
    step(sv(1,0, 0,1,0, 1,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,0,0);

    // branch on load in MEM: one stall, eq taken in resolve
    step(sv(1,0, 0,0,1, 0,0, 4'd0,4'd4, 4'd0,4'd4, 0,0,1), 0,0,0);
    step(sv(1,0, 0,0,1, 0,0, 4'd0,4'd4, 4'd0,4'd4, 0,0,1), 0,0,1);
    step(sv(1,0, 0,0,0, 0,1, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,1,0);

    // unstalled le taken / gt not taken / EX match without regWrite
    step(sv(1,0, 0,1,0, 0,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 1,0,0);
    step(sv(1,0, 1,0,0, 0,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,0,0);
    step(sv(1,0, 0,0,1, 0,1, 4'd6,4'd0, 4'd6,4'd0, 0,0,0), 1,0,0);

    // register zero never creates a hazard
    rz = sv(1,0, 0,0,0, 0,0, 4'd0,4'd0, 4'd0,4'd0, 1,1,0);
    step(rz, 0,0,0);
    step(sv(1,0, 0,0,1, 0,1, 4'd0,4'd0, 4'd0,4'd0, 1,1,0), 1,0,0);
    step(z,  0,0,0);

    // reset mid-stall abandons the branch
    step(bl, 0,0,0);
    step(bl, 0,0,1);
    step(sv(0,0, 1,0,0, 1,0, 4'd0,4'd5, 4'd5,4'd0, 1,1,0), 0,0,0);
    step(sv(1,0, 0,0,0, 1,0, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 0,0,0);
    step(z,  0,0,0);

    // saturation of the taken counter
    for (int i = 0; i < 70000; i++) step(t, 1,0,0);
    // clear wins over a simultaneous increment
    step(sv(1,1, 0,0,1, 0,1, 4'd0,4'd0, 4'd0,4'd0, 0,0,0), 1,0,0);
    step(z,  0,0,0);
    step(lu, 0,0,0);
    step(lu, 0,0,1);
    step(z,  0,0,0);
    step(z,  0,0,0);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports gt_bra, le_bra, eq_bra, inputs, 1 each: branch type of the instruction in ID, from the opcode decoder.
REQ-004 SHALL have ports cmp_gt, cmp_eq, inputs, 1 each: signed compare of the forwarded ID operands (rs > rt, rs == rt).
REQ-005 SHALL have ports id_rs, id_rt, inputs, 4 each: source register fields in ID.
REQ-006 SHALL have ports ex_rd, mem_rd, inputs, 4 each; ex_regWrite, ex_memRead, mem_memRead, inputs, 1 each: destination info for EX and MEM.
REQ-007 SHALL have port cnt_clr, input, 1: synchronous clear of the statistics counters.
REQ-008 SHALL have ports pcsrc1, pcsrc2, outputs, 1 each: branch taken, resolved in ID without stall (pcsrc1) or after stall (pcsrc2).
REQ-009 SHALL have ports pc_write, if_id_write, outputs, 1 each (1 = update); id_bubble, output, 1 (1 = insert NOP into ID/EX).
REQ-010 SHALL have ports br_taken_cnt, stall_cyc_cnt, outputs, 16 each: statistics counters.

Function
REQ-011 SHALL define is_br = gt_bra|le_bra|eq_bra and match(r) = (r != 0) & (r == id_rs | r == id_rt).
REQ-012 SHALL compute taken by priority eq>gt>le: eq_bra&cmp_eq; else gt_bra&cmp_gt; else le_bra&~cmp_gt.
REQ-013 SHALL implement states IDLE, STALL, RESOLVE, plus a 2-bit stall counter scnt and a latched branch flag br_l with latched type bits.
REQ-014 IDLE, branch hazard: is_br & ex_regWrite & match(ex_rd) -> STALL, scnt = 2 if ex_memRead else 1; else is_br & mem_memRead & match(mem_rd) -> STALL, scnt = 1; br_l = 1 and type latched in both cases.
REQ-015 IDLE, load-use: ~is_br & ex_memRead & match(ex_rd) -> STALL, scnt = 1, br_l = 0.
REQ-016 IDLE, no hazard: pcsrc1 = is_br & taken, same cycle (combinational); state stays IDLE.
REQ-017 STALL: pc_write = 0, if_id_write = 0, id_bubble = 1, pcsrc1 = pcsrc2 = 0; scnt decrements each cycle; at scnt == 1 move to RESOLVE if br_l, else IDLE.
REQ-018 RESOLVE: pcsrc2 = taken evaluated with the latched type and current cmp flags; no stall; move to IDLE next cycle; hazard checks are not evaluated in RESOLVE.
REQ-019 Outside STALL: pc_write = if_id_write = 1 and id_bubble = 0.
REQ-020 pcsrc1 and pcsrc2 SHALL never both be 1 in the same cycle.
REQ-021 br_taken_cnt SHALL increment by 1 on each cycle with pcsrc1|pcsrc2.
REQ-022 stall_cyc_cnt SHALL increment by 1 on each STALL cycle.
REQ-023 Both counters SHALL saturate at 16'hFFFF; cnt_clr zeroes them and wins over a simultaneous increment.

Reset
REQ-024 rst_n = 0 SHALL immediately force IDLE, scnt = 0, br_l = 0, type latch = 0, counters = 0, independent of clk.
REQ-025 During reset SHALL drive pcsrc1 = pcsrc2 = 0, id_bubble = 0, pc_write = if_id_write = 1.
REQ-026 Reset asserted mid-STALL or in RESOLVE SHALL abandon the pending branch with no pcsrc2 pulse after release.

Verification
REQ-027 Reset: eq_bra=1, cmp_eq=1, no hazard -> pcsrc1=1 in the same cycle, pc_write=1, br_taken_cnt 0->1.
REQ-028 Load-use, non-branch: ex_memRead=1, ex_regWrite=1, ex_rd=3, id_rs=3 -> exactly 1 stall cycle (pc_write=0, id_bubble=1), then IDLE, stall_cyc_cnt=1.
REQ-029 Branch on load: gt_bra=1, ex_memRead=1, ex_regWrite=1, ex_rd=5=id_rt -> 2 stall cycles, then RESOLVE with cmp_gt=1 -> pcsrc2=1 for one cycle, pcsrc1 stays 0.
REQ-030 Branch on ALU result: le_bra=1, ex_regWrite=1, ex_memRead=0, ex_rd=2=id_rs, cmp_gt=1 in RESOLVE -> 1 stall cycle, then pcsrc2=0.
REQ-031 Register zero: ex_memRead=1, ex_regWrite=1, ex_rd=0=id_rs -> no stall.
REQ-032 Abort and saturation: rst_n pulsed low during STALL -> IDLE, no pcsrc2 after release; 70000 taken branches -> br_taken_cnt=16'hFFFF; cnt_clr together with an increment -> 0.
